i2c_scl_timer: RTL and testbench

//  Downstream consumer of the 50MHz system clock: divides Clk into I2C SCL bit timing.

---
 rtl/i2c_scl_timer_pkg.sv | 22 ++
 rtl/i2c_sync2.sv | 25 ++
 rtl/i2c_scl_timer.sv | 140 ++++++++++++++
 tb/tb_i2c_scl_timer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_scl_timer_pkg.sv
// Shared types and defaults for the I2C SCL timing block.
// Also used by the bit engine for the state encoding and default timing values.
package i2c_scl_timer_pkg;

    localparam int CNT_W_D        = 16;
    localparam int DEF_PRESCALE_D = 124;
    localparam int STRETCH_MAX_D  = 25000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOW1  = 3'd1,
        ST_LOW2  = 3'd2,
        ST_HIGH1 = 3'd3,
        ST_HIGH2 = 3'd4
    } scl_state_t;

    // Bits needed to hold 0..max_val in the stretch counter.
    function automatic int stretch_bits(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/i2c_sync2.sv
// Two-flop synchroniser for an asynchronous bus line, resets to the idle (released) level.
// Latency: 2 Clk from d to q.
// Backpressure: none, free-running.
module i2c_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic Clk,
    input  logic Rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/i2c_scl_timer.sv
// SCL bit-timing generator: splits each SCL cycle into four quarters and drives open-drain SCL.
// Latency: Scl_fall one Clk after IDLE sees Enable; all phase strobes registered and one Clk wide.
// Backpressure: a slave holding SCL low stalls HIGH1 until release or the stretch limit (Timeout).
module i2c_scl_timer
    import i2c_scl_timer_pkg::*;
#(
    parameter int CNT_W        = CNT_W_D,
    parameter int DEF_PRESCALE = DEF_PRESCALE_D,
    parameter int STRETCH_MAX  = STRETCH_MAX_D
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Enable,
    input  logic [CNT_W-1:0] Prescale,
    input  logic             Scl_i,
    output logic             Scl_oe,
    output logic             Busy,
    output logic             Scl_fall,
    output logic             Data_chg,
    output logic             Scl_rise,
    output logic             Sample,
    output logic             Stretch,
    output logic             Timeout
);

    localparam int SW = stretch_bits(STRETCH_MAX);

    scl_state_t       state;
    logic [CNT_W-1:0] q;
    logic [CNT_W-1:0] presc;
    logic [SW-1:0]    scnt;
    logic             scl_s;
    logic             q_done;

    i2c_sync2 #(.RST_VAL(1'b1)) u_scl_sync (
        .Clk (Clk),
        .Rst (Rst),
        .d   (Scl_i),
        .q   (scl_s)
    );

    assign q_done  = (q == presc);
    // Decoded from registered state and the synchroniser output only, so glitch-free.
    assign Stretch = (state == ST_HIGH1) && !scl_s;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= ST_IDLE;
            q        <= '0;
            presc    <= CNT_W'(DEF_PRESCALE);
            scnt     <= '0;
            Scl_oe   <= 1'b0;
            Busy     <= 1'b0;
            Scl_fall <= 1'b0;
            Data_chg <= 1'b0;
            Scl_rise <= 1'b0;
            Sample   <= 1'b0;
            Timeout  <= 1'b0;
        end else begin
            Scl_fall <= 1'b0;
            Data_chg <= 1'b0;
            Scl_rise <= 1'b0;
            Sample   <= 1'b0;
            Timeout  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Enable) begin
                        state    <= ST_LOW1;
                        presc    <= Prescale;
                        q        <= '0;
                        Scl_oe   <= 1'b1;
                        Busy     <= 1'b1;
                        Scl_fall <= 1'b1;
                    end
                end
                ST_LOW1: begin
                    if (q_done) begin
                        state    <= ST_LOW2;
                        q        <= '0;
                        Data_chg <= 1'b1;
                    end else begin
                        q <= q + CNT_W'(1);
                    end
                end
                ST_LOW2: begin
                    if (q_done) begin
                        state    <= ST_HIGH1;
                        q        <= '0;
                        scnt     <= '0;
                        Scl_oe   <= 1'b0;
                        Scl_rise <= 1'b1;
                    end else begin
                        q <= q + CNT_W'(1);
                    end
                end
                ST_HIGH1: begin
                    // The high quarter only starts counting once the line is seen released.
                    if (!scl_s) begin
                        if (scnt == SW'(STRETCH_MAX)) begin
                            state   <= ST_IDLE;
                            q       <= '0;
                            Busy    <= 1'b0;
                            Timeout <= 1'b1;
                        end else begin
                            scnt <= scnt + SW'(1);
                        end
                    end else if (q_done) begin
                        state  <= ST_HIGH2;
                        q      <= '0;
                        Sample <= 1'b1;
                    end else begin
                        q <= q + CNT_W'(1);
                    end
                end
                ST_HIGH2: begin
                    if (q_done) begin
                        q <= '0;
                        if (Enable) begin
                            state    <= ST_LOW1;
                            Scl_oe   <= 1'b1;
                            Scl_fall <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            Busy  <= 1'b0;
                        end
                    end else begin
                        q <= q + CNT_W'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    q      <= '0;
                    Scl_oe <= 1'b0;
                    Busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_scl_timer.sv
// Bench for i2c_scl_timer: cycle table at Prescale=0, modelled runs with slave stretching,
// reset in HIGH1, and a stretch timeout on a second instance with a short limit.
module tb_i2c_scl_timer;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Enable = 1'b0;
    logic [15:0] Prescale = 16'd0;
    logic        Scl_i;
    logic        Scl_oe, Busy, Scl_fall, Data_chg, Scl_rise, Sample, Stretch, Timeout;

    logic        en2 = 1'b0;
    logic [15:0] presc2 = 16'd4;
    logic        scl2_i = 1'b0;
    logic        Scl_oe2, Busy2, Scl_fall2, Data_chg2, Scl_rise2, Sample2, Stretch2, Timeout2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Slave model: holds SCL low for cur_h cycles starting at each Scl_rise.
    int   h_q[$];
    int   cur_h = 0;
    int   age = 1000000;
    logic slave_low;
    assign slave_low = (age < cur_h);
    assign Scl_i = ~Scl_oe & ~slave_low;

    i2c_scl_timer dut (
        .Clk(Clk), .Rst(Rst), .Enable(Enable), .Prescale(Prescale), .Scl_i(Scl_i),
        .Scl_oe(Scl_oe), .Busy(Busy), .Scl_fall(Scl_fall), .Data_chg(Data_chg),
        .Scl_rise(Scl_rise), .Sample(Sample), .Stretch(Stretch), .Timeout(Timeout)
    );

    i2c_scl_timer #(.STRETCH_MAX(100)) dut_to (
        .Clk(Clk), .Rst(Rst), .Enable(en2), .Prescale(presc2), .Scl_i(scl2_i),
        .Scl_oe(Scl_oe2), .Busy(Busy2), .Scl_fall(Scl_fall2), .Data_chg(Data_chg2),
        .Scl_rise(Scl_rise2), .Sample(Sample2), .Stretch(Stretch2), .Timeout(Timeout2)
    );

    always #10 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // Event recorder: kinds 0=fall 1=data_chg 2=rise 3=sample 4=timeout.
    logic       rec = 1'b0;
    int         ev_t[$];
    int         ev_k[$];
    int         stretch_cnt = 0;
    logic [4:0] mon_s;

    always @(negedge Clk) begin
        mon_s = {Scl_fall, Data_chg, Scl_rise, Sample, Timeout};
        if (Scl_rise) begin
            cur_h = (h_q.size() > 0) ? h_q.pop_front() : 0;
            age   = 0;
        end else if (age < 1000000) begin
            age = age + 1;
        end
        if (rec) begin
            if (Stretch) stretch_cnt++;
            if (mon_s != 5'b0) begin
                checks++;
                if ($countones(mon_s) != 1) begin
                    errors++;
                    $display("FAIL strobe_onehot cyc=%0d got=%b want exactly one bit", cyc, mon_s);
                end
                if (Scl_fall) begin ev_t.push_back(cyc); ev_k.push_back(0); end
                if (Data_chg) begin ev_t.push_back(cyc); ev_k.push_back(1); end
                if (Scl_rise) begin ev_t.push_back(cyc); ev_k.push_back(2); end
                if (Sample)   begin ev_t.push_back(cyc); ev_k.push_back(3); end
                if (Timeout)  begin ev_t.push_back(cyc); ev_k.push_back(4); end
            end
        end
    end

    // n full SCL cycles at prescale p; Enable drops during the last LOW1 and Prescale is
    // overwritten with pmid while busy. Expected strobe times come from quarter arithmetic.
    task automatic run_case(input int p, input int n, input int hfix, input int hmax,
                            input logic [15:0] pmid);
        int t, rise, smp, t_last, t_idle, exp_str, nmin;
        int exp_t[$];
        int exp_k[$];
        @(negedge Clk);
        Prescale = 16'(p);
        ev_t.delete(); ev_k.delete(); h_q.delete();
        stretch_cnt = 0;
        exp_str = 0;
        t = cyc + 1;
        t_last = t;
        for (int k = 0; k < n; k++) begin
            int h;
            h = (hfix >= 0) ? hfix : int'($urandom_range(hmax, 0));
            h_q.push_back(h);
            rise = t + 2 * (p + 1);
            smp  = rise + h + 2 + (p + 1);
            exp_t.push_back(t);         exp_k.push_back(0);
            exp_t.push_back(t + p + 1); exp_k.push_back(1);
            exp_t.push_back(rise);      exp_k.push_back(2);
            exp_t.push_back(smp);       exp_k.push_back(3);
            exp_str += h + 2;
            t_last = t;
            t = smp + p + 1;
        end
        t_idle = t;
        rec = 1'b1;
        Enable = 1'b1;
        @(negedge Clk);
        Prescale = pmid;
        while (cyc < t_last) @(negedge Clk);
        Enable = 1'b0;
        while (cyc < t_idle - 1) @(negedge Clk);
        checks++;
        if (!(Busy && !Scl_oe)) begin
            errors++;
            $display("FAIL last_high2 p=%0d got busy=%b oe=%b want busy=1 oe=0", p, Busy, Scl_oe);
        end
        @(negedge Clk);
        checks++;
        if (Busy || Scl_oe) begin
            errors++;
            $display("FAIL idle_after_stop p=%0d got busy=%b oe=%b want 0 0", p, Busy, Scl_oe);
        end
        repeat (3) @(negedge Clk);
        rec = 1'b0;
        checks++;
        if (ev_t.size() != exp_t.size()) begin
            errors++;
            $display("FAIL event_count p=%0d got %0d want %0d", p, ev_t.size(), exp_t.size());
        end
        nmin = (ev_t.size() < exp_t.size()) ? ev_t.size() : exp_t.size();
        for (int i = 0; i < nmin; i++) begin
            checks++;
            if (ev_t[i] != exp_t[i] || ev_k[i] != exp_k[i]) begin
                errors++;
                $display("FAIL event[%0d] p=%0d got t=%0d kind=%0d want t=%0d kind=%0d",
                         i, p, ev_t[i], ev_k[i], exp_t[i], exp_k[i]);
            end
        end
        checks++;
        if (stretch_cnt != exp_str) begin
            errors++;
            $display("FAIL stretch_cycles p=%0d got %0d want %0d", p, stretch_cnt, exp_str);
        end
    endtask

    typedef struct packed {
        logic       rst;
        logic       en;
        logic [7:0] exp;   // {oe, busy, fall, data_chg, rise, sample, stretch, timeout}
    } vec_t;

    vec_t tbl [16];

    initial begin
        logic [7:0] got;
        logic       bad;
        int         got_t, exp_to;

        // Prescale=0 trace: one-cycle Enable pulse gives one full 6-cycle SCL period, then a
        // continuous run, then reset in LOW1.
        tbl[0]  = '{1'b1, 1'b1, 8'b0000_0000};
        tbl[1]  = '{1'b0, 1'b1, 8'b1110_0000};
        tbl[2]  = '{1'b0, 1'b0, 8'b1101_0000};
        tbl[3]  = '{1'b0, 1'b0, 8'b0100_1010};
        tbl[4]  = '{1'b0, 1'b0, 8'b0100_0010};
        tbl[5]  = '{1'b0, 1'b0, 8'b0100_0000};
        tbl[6]  = '{1'b0, 1'b0, 8'b0100_0100};
        tbl[7]  = '{1'b0, 1'b0, 8'b0000_0000};
        tbl[8]  = '{1'b0, 1'b1, 8'b1110_0000};
        tbl[9]  = '{1'b0, 1'b1, 8'b1101_0000};
        tbl[10] = '{1'b0, 1'b1, 8'b0100_1010};
        tbl[11] = '{1'b0, 1'b1, 8'b0100_0010};
        tbl[12] = '{1'b0, 1'b1, 8'b0100_0000};
        tbl[13] = '{1'b0, 1'b1, 8'b0100_0100};
        tbl[14] = '{1'b0, 1'b1, 8'b1110_0000};
        tbl[15] = '{1'b1, 1'b1, 8'b0000_0000};

        Prescale = 16'd0;
        repeat (2) @(negedge Clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge Clk);
            Rst    = tbl[i].rst;
            Enable = tbl[i].en;
            @(posedge Clk);
            #1;
            got = {Scl_oe, Busy, Scl_fall, Data_chg, Scl_rise, Sample, Stretch, Timeout};
            checks++;
            if (got !== tbl[i].exp) begin
                errors++;
                $display("FAIL table[%0d] got=%b want=%b", i, got, tbl[i].exp);
            end
        end

        // Reset released with Enable low: nothing may happen.
        @(negedge Clk);
        Rst = 1'b0;
        Enable = 1'b0;
        bad = 1'b0;
        repeat (5) begin
            @(negedge Clk);
            if ({Scl_oe, Busy, Scl_fall, Data_chg, Scl_rise, Sample, Stretch, Timeout} != 8'b0)
                bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL quiet_after_reset got activity want none");
        end

        run_case(124, 2, 0, 0, 16'd3);      // 125/125/127/125 spacing, Prescale=3 mid-run ignored
        run_case(3, 2, 0, 0, 16'd124);      // restart picks up the new prescale
        run_case(124, 1, 300, 0, 16'd0);    // 300-cycle stretch: Sample 427 after Scl_rise
        for (int r = 0; r < 6; r++) begin
            run_case(int'($urandom_range(12, 0)), int'($urandom_range(3, 1)), -1, 20,
                     16'($urandom));
        end

        // Reset asserted between clock edges in HIGH1.
        @(negedge Clk);
        Prescale = 16'd10;
        Enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (Scl_rise) break;
            @(negedge Clk);
        end
        checks++;
        if (!Scl_rise) begin
            errors++;
            $display("FAIL rst_high1_reach got no Scl_rise want one within 100 cycles");
        end
        @(negedge Clk);
        Enable = 1'b0;
        checks++;
        if (!(Busy && Stretch && !Scl_oe)) begin
            errors++;
            $display("FAIL rst_high1_pre got busy=%b stretch=%b oe=%b want 1 1 0", Busy, Stretch, Scl_oe);
        end
        #3;
        Rst = 1'b1;
        #1;
        got = {Scl_oe, Busy, Scl_fall, Data_chg, Scl_rise, Sample, Stretch, Timeout};
        checks++;
        if (got != 8'b0) begin
            errors++;
            $display("FAIL rst_high1_async got=%b want=00000000", got);
        end
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            @(negedge Clk);
            if ({Scl_oe, Busy, Scl_fall, Data_chg, Scl_rise, Sample} != 6'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rst_high1_quiet got activity want none");
        end

        // Stretch timeout with STRETCH_MAX=100 and SCL held low.
        @(negedge Clk);
        presc2 = 16'd4;
        en2 = 1'b1;
        exp_to = cyc + 1 + 2 * 5 + 101;
        @(negedge Clk);
        en2 = 1'b0;
        got_t = -1;
        for (int i = 0; i < 400; i++) begin
            if (Timeout2) begin
                got_t = cyc;
                break;
            end
            @(negedge Clk);
        end
        checks++;
        if (got_t != exp_to) begin
            errors++;
            $display("FAIL timeout_time got cyc=%0d want cyc=%0d", got_t, exp_to);
        end
        @(negedge Clk);
        checks++;
        if ({Timeout2, Busy2, Scl_oe2, Stretch2} != 4'b0) begin
            errors++;
            $display("FAIL timeout_after got to=%b busy=%b oe=%b stretch=%b want all 0",
                     Timeout2, Busy2, Scl_oe2, Stretch2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
